// File: rtl/spi_slave_burst_if.sv
// rtl/spi_slave_burst_if.sv - SPI pin and RAM rx/tx handshake bundle for spi_slave_burst
//
// Purpose: groups the SPI pins (SS_n/MOSI/MISO), the RAM-side rx/tx handshake
// and the status flags into one interface.
// Ports (slave view):
//   SS_n, MOSI          in   SPI slave select (active low) and serial data in
//   MISO                out  serial data out, MSB first
//   rx_data, rx_valid   out  {cmd[1:0], payload} word to RAM, one-cycle valid pulse
//   tx_data, tx_valid   in   RAM read data, one-cycle valid pulse
//   cmd_err             out  one-cycle pulse on command/frame-type mismatch
//   busy                out  high while the slave is not idle
interface spi_slave_burst_if #(
  parameter int WIDTH = 8
) ();
  logic             SS_n;
  logic             MOSI;
  logic             MISO;
  logic [WIDTH+1:0] rx_data;
  logic             rx_valid;
  logic [WIDTH-1:0] tx_data;
  logic             tx_valid;
  logic             cmd_err;
  logic             busy;

  modport slave (
    input  SS_n, MOSI, tx_data, tx_valid,
    output MISO, rx_data, rx_valid, cmd_err, busy
  );

  modport master (
    output SS_n, MOSI, tx_data, tx_valid,
    input  MISO, rx_data, rx_valid, cmd_err, busy
  );
endinterface

// File: rtl/spi_slave_burst.sv
// rtl/spi_slave_burst.sv - SPI slave front-end with configurable width and burst streaming
//
// Purpose: deserialises MOSI frames into {cmd, payload} words for the RAM and
// serialises RAM read data onto MISO. Optional burst mode streams further
// write-data words, or further read-data words, within one SS_n window.
// Ports:
//   clk    in  system clock, all logic on the rising edge
//   rst_n  in  synchronous active-low reset
//   bus    spi_slave_burst_if.slave (SPI pins, rx/tx handshake, cmd_err, busy)
module spi_slave_burst #(
  parameter int WIDTH    = 8,
  parameter bit BURST_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  spi_slave_burst_if.slave  bus
);

  localparam int CW = $clog2(WIDTH + 2);
  localparam logic [CW-1:0] LAST_CMD = CW'(WIDTH + 1);  // last bit of a cmd+payload word
  localparam logic [CW-1:0] LAST_PAY = CW'(WIDTH - 1);  // last bit of a payload-only word

  typedef enum logic [2:0] {
    IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA_RX, WAIT_TX, SHIFT_OUT, WR_BURST
  } state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   shreg;
  logic [WIDTH-1:0] txreg;
  logic             rd_addr_seen;
  logic             miso_r;
  logic [WIDTH+1:0] rx_data_r;
  logic             rx_valid_r;
  logic             cmd_err_r;

  logic [WIDTH+1:0] word;       // shift register including the bit being sampled now
  logic [WIDTH-1:0] burst_pay;  // payload-only word for write bursts
  logic             last_cmd;
  logic             last_pay;
  logic             cmd_ok;

  assign word      = {shreg, bus.MOSI};
  assign burst_pay = {shreg[WIDTH-2:0], bus.MOSI};
  assign last_cmd  = (cnt == LAST_CMD);
  assign last_pay  = (cnt == LAST_PAY);

  always_comb begin
    cmd_ok = 1'b0;
    case (state)
      WRITE:        cmd_ok = ~word[WIDTH+1];
      READ_ADD:     cmd_ok = (word[WIDTH+1:WIDTH] == 2'b10);
      READ_DATA_RX: cmd_ok = (word[WIDTH+1:WIDTH] == 2'b11);
      default:      cmd_ok = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    if (state != IDLE && bus.SS_n) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (!bus.SS_n) state_nxt = CHK_CMD;
        CHK_CMD: begin
          if (!bus.MOSI)         state_nxt = WRITE;
          else if (rd_addr_seen) state_nxt = READ_DATA_RX;
          else                   state_nxt = READ_ADD;
        end
        WRITE, READ_ADD, READ_DATA_RX: begin
          if (last_cmd) begin
            if (!cmd_ok)
              state_nxt = IDLE;
            else if (state == WRITE && word[WIDTH+1:WIDTH] == 2'b01 && BURST_EN)
              state_nxt = WR_BURST;
            else if (state == READ_DATA_RX)
              state_nxt = WAIT_TX;
            else
              state_nxt = IDLE;
          end
        end
        WR_BURST:  state_nxt = WR_BURST;
        WAIT_TX:   if (bus.tx_valid) state_nxt = SHIFT_OUT;
        SHIFT_OUT: if (last_pay) state_nxt = BURST_EN ? WAIT_TX : IDLE;
        default:   state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      shreg        <= '0;
      txreg        <= '0;
      rd_addr_seen <= 1'b0;
      miso_r       <= 1'b0;
      rx_data_r    <= '0;
      rx_valid_r   <= 1'b0;
      cmd_err_r    <= 1'b0;
    end else begin
      state      <= state_nxt;
      rx_valid_r <= 1'b0;
      cmd_err_r  <= 1'b0;
      if (state != IDLE && bus.SS_n) begin
        // Abort: partial word is dropped, rd_addr_seen survives.
        cnt    <= '0;
        miso_r <= 1'b0;
      end else begin
        case (state)
          IDLE, CHK_CMD: begin
            cnt    <= '0;
            miso_r <= 1'b0;
          end
          WRITE, READ_ADD, READ_DATA_RX: begin
            shreg <= word[WIDTH:0];
            if (last_cmd) begin
              cnt <= '0;
              if (cmd_ok) begin
                rx_valid_r <= 1'b1;
                rx_data_r  <= word;
                if (state == READ_ADD)     rd_addr_seen <= 1'b1;
                if (state == READ_DATA_RX) rd_addr_seen <= 1'b0;
              end else begin
                cmd_err_r <= 1'b1;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          WR_BURST: begin
            shreg <= word[WIDTH:0];
            if (last_pay) begin
              cnt        <= '0;
              rx_valid_r <= 1'b1;
              rx_data_r  <= {2'b01, burst_pay};
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          WAIT_TX: begin
            cnt    <= '0;
            miso_r <= 1'b0;
            if (bus.tx_valid) begin
              // MSB goes out immediately; the rest queues in txreg.
              miso_r <= bus.tx_data[WIDTH-1];
              txreg  <= {bus.tx_data[WIDTH-2:0], 1'b0};
            end
          end
          SHIFT_OUT: begin
            if (last_pay) begin
              cnt    <= '0;
              miso_r <= 1'b0;
              if (BURST_EN) begin
                // Next read request; RAM supplies the following address itself.
                rx_valid_r <= 1'b1;
                rx_data_r  <= {2'b11, {WIDTH{1'b0}}};
              end
            end else begin
              miso_r <= txreg[WIDTH-1];
              txreg  <= {txreg[WIDTH-2:0], 1'b0};
              cnt    <= cnt + 1'b1;
            end
          end
          default: begin
            cnt    <= '0;
            miso_r <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.MISO     = miso_r;
  assign bus.rx_data  = rx_data_r;
  assign bus.rx_valid = rx_valid_r;
  assign bus.cmd_err  = cmd_err_r;
  assign bus.busy     = (state != IDLE);

endmodule
